// File: rtl/i2c_slave.sv
// ---------------------------------------------------------------------------
// i2c_slave -- single-address I2C target on an open-drain SCL/SDA bus.
//
// SCL and SDA are oversampled through SYNC_STAGES flops. START and STOP are
// detected in every state and take priority over bit events. The 7-bit
// ADDRESS is matched and ACKed. Written bytes come out on rxdata/rx_valid.
// Read bytes are taken from txdata/tx_valid, with tx_req asking for the next
// one.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   scl, sda            open-drain bus lines (driven only as 0 or z)
//   txdata, tx_valid    byte for the next read data phase and its qualifier
//   tx_req              one-clk pulse: the next read byte is needed
//   rxdata, rx_valid    last written byte, one-clk update pulse
//   rw                  R/W bit of the current addressed transaction
//   busy                high from address match to STOP/non-matching restart
//   start_det, stop_det one-clk pulses on START (or Sr) and STOP
//   tx_underrun         one-clk pulse: read byte loaded while tx_valid low
//
// Build option I2C_SLAVE_STRETCH_EN: when defined, a read byte that is due
// while tx_valid is low stretches SCL low until tx_valid arrives, and
// tx_underrun never pulses. When undefined, SCL is never driven and 8'hFF is
// returned instead.
// ---------------------------------------------------------------------------
module i2c_slave #(
    parameter logic [6:0] ADDRESS     = 7'h52,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    inout  wire        scl,
    inout  wire        sda,
    input  logic [7:0] txdata,
    input  logic       tx_valid,
    output logic       tx_req,
    output logic [7:0] rxdata,
    output logic       rx_valid,
    output logic       rw,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det,
    output logic       tx_underrun
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    // ---------------- input synchronizers and edge detection ----------------
    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_prev, r_sda_prev;
    logic                   w_scl, w_sda;
    logic                   w_scl_rise, w_scl_fall, w_start, w_stop;

    // Synchronizers reset to 1 (idle bus) so that leaving reset cannot
    // fabricate a START or a falling SCL edge.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the value from before the clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise =  w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl &  r_scl_prev;
    assign w_start    = w_scl & r_scl_prev &  r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev &  w_sda;

    // ---------------- FSM and datapath registers ----------------
    state_t     r_state, w_state_n;
    logic [3:0] r_cnt, w_cnt_n;          // bits seen in the current byte / 9th-clock flag
    logic [7:0] r_shift, w_shift_n;
    logic [7:0] r_rxdata, w_rxdata_n;
    logic       r_rw, w_rw_n;
    logic       r_busy, w_busy_n;
    logic       r_sda_low, w_sda_low_n;
    logic       r_tx_req, w_tx_req_n;
    logic       r_rx_valid, w_rx_valid_n;
    logic       r_start_det, w_start_det_n;
    logic       r_stop_det, w_stop_det_n;
    logic       r_underrun, w_underrun_n;
    logic       w_load;                  // load the next read byte this cycle
`ifdef I2C_SLAVE_STRETCH_EN
    logic       r_stretch, w_stretch_n;  // waiting for tx_valid with SCL held
    logic       r_scl_low, w_scl_low_n;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_rxdata    <= '0;
            r_rw        <= 1'b0;
            r_busy      <= 1'b0;
            r_sda_low   <= 1'b0;
            r_tx_req    <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
            r_underrun  <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
            r_stretch   <= 1'b0;
            r_scl_low   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_shift     <= w_shift_n;
            r_rxdata    <= w_rxdata_n;
            r_rw        <= w_rw_n;
            r_busy      <= w_busy_n;
            r_sda_low   <= w_sda_low_n;
            r_tx_req    <= w_tx_req_n;
            r_rx_valid  <= w_rx_valid_n;
            r_start_det <= w_start_det_n;
            r_stop_det  <= w_stop_det_n;
            r_underrun  <= w_underrun_n;
`ifdef I2C_SLAVE_STRETCH_EN
            r_stretch   <= w_stretch_n;
            r_scl_low   <= w_scl_low_n;
`endif
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_shift_n     = r_shift;
        w_rxdata_n    = r_rxdata;
        w_rw_n        = r_rw;
        w_busy_n      = r_busy;
        w_sda_low_n   = r_sda_low;
        w_tx_req_n    = 1'b0;
        w_rx_valid_n  = 1'b0;
        w_start_det_n = 1'b0;
        w_stop_det_n  = 1'b0;
        w_underrun_n  = 1'b0;
        w_load        = 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
        w_stretch_n   = r_stretch;
        // SCL is released one clk after the stretched byte has been loaded.
        w_scl_low_n   = r_scl_low & r_stretch;
`endif

        if (w_stop || w_start) begin
            w_state_n     = w_stop ? IDLE : ADDR;
            w_stop_det_n  = w_stop;
            w_start_det_n = w_start;
            w_sda_low_n   = 1'b0;
            w_cnt_n       = '0;
            // A repeated START keeps busy until the new address is judged.
            if (w_stop) w_busy_n = 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
            w_stretch_n   = 1'b0;
            w_scl_low_n   = 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE, IGNORE: ;
                ADDR, WR_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_n = {r_shift[6:0], w_sda};
                        w_cnt_n   = r_cnt + 4'd1;
                    end else if (w_scl_fall && r_cnt == 4'd8) begin
                        w_cnt_n = '0;
                        if (r_state == WR_DATA) begin
                            w_rxdata_n   = r_shift;
                            w_rx_valid_n = 1'b1;
                            w_sda_low_n  = 1'b1;
                            w_state_n    = WR_ACK;
                        end else if (r_shift[7:1] == ADDRESS) begin
                            w_rw_n      = r_shift[0];
                            w_busy_n    = 1'b1;
                            w_sda_low_n = 1'b1;
                            w_tx_req_n  = r_shift[0];
                            w_state_n   = ADDR_ACK;
                        end else begin
                            w_busy_n  = 1'b0;
                            w_state_n = IGNORE;
                        end
                    end
                end
                ADDR_ACK, WR_ACK: begin
                    // r_cnt==1 marks that the 9th rising edge has been seen.
                    if (w_scl_rise) begin
                        w_cnt_n = 4'd1;
                    end else if (w_scl_fall && r_cnt == 4'd1) begin
                        w_cnt_n     = '0;
                        w_sda_low_n = 1'b0;
                        if (r_state == ADDR_ACK && r_rw) begin
                            w_load    = 1'b1;
                            w_state_n = RD_DATA;
                        end else begin
                            w_state_n = WR_DATA;
                        end
                    end
                end
                RD_DATA: begin
`ifdef I2C_SLAVE_STRETCH_EN
                    if (r_stretch) begin
                        if (tx_valid) begin
                            w_shift_n   = txdata;
                            w_sda_low_n = ~txdata[7];
                            w_stretch_n = 1'b0;
                        end
                    end else
`endif
                    if (w_scl_rise) begin
                        w_cnt_n = r_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_cnt_n     = '0;
                            w_sda_low_n = 1'b0;
                            w_state_n   = RD_ACK;
                        end else begin
                            w_shift_n   = {r_shift[6:0], 1'b1};
                            w_sda_low_n = ~r_shift[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (w_scl_rise && r_cnt == 4'd0) begin
                        if (!w_sda) begin
                            w_tx_req_n = 1'b1;
                            w_cnt_n    = 4'd1;
                        end else begin
                            w_state_n = IGNORE;
                        end
                    end else if (w_scl_fall && r_cnt == 4'd1) begin
                        w_cnt_n   = '0;
                        w_load    = 1'b1;
                        w_state_n = RD_DATA;
                    end
                end
                default: w_state_n = IDLE;
            endcase

            if (w_load) begin
                if (tx_valid) begin
                    w_shift_n   = txdata;
                    w_sda_low_n = ~txdata[7];
                end else begin
`ifdef I2C_SLAVE_STRETCH_EN
                    w_stretch_n  = 1'b1;
                    w_scl_low_n  = 1'b1;
                    w_sda_low_n  = 1'b0;
`else
                    w_shift_n    = 8'hFF;
                    w_sda_low_n  = 1'b0;
                    w_underrun_n = 1'b1;
`endif
                end
            end
        end
    end

    // ---------------- bus drivers and outputs ----------------
    assign sda = r_sda_low ? 1'b0 : 1'bz;
`ifdef I2C_SLAVE_STRETCH_EN
    assign scl = r_scl_low ? 1'b0 : 1'bz;
`else
    assign scl = 1'bz;
`endif

    assign tx_req      = r_tx_req;
    assign rxdata      = r_rxdata;
    assign rx_valid    = r_rx_valid;
    assign rw          = r_rw;
    assign busy        = r_busy;
    assign start_det   = r_start_det;
    assign stop_det    = r_stop_det;
    assign tx_underrun = r_underrun;

endmodule

// File: tb/tb_i2c_slave.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave -- self-checking bench for i2c_slave.
// A bit-banged master drives the pulled-up bus. Written bytes are pushed to a
// scoreboard queue and popped when rx_valid fires. Read bytes are pushed when
// txdata is set up and popped when the master has clocked the byte in.
// ---------------------------------------------------------------------------
module tb_i2c_slave;

    localparam int Q = 4;  // clk periods per quarter of an SCL bit

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    wire        scl_bus, sda_bus;
    logic       m_scl_low, m_sda_low;
    logic [7:0] txdata;
    logic       tx_valid;
    logic       tx_req, rx_valid, rw, busy, start_det, stop_det, tx_underrun;
    logic [7:0] rxdata;

    pullup (scl_bus);
    pullup (sda_bus);
    assign scl_bus = m_scl_low ? 1'b0 : 1'bz;
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave #(.ADDRESS(7'h52), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .scl(scl_bus), .sda(sda_bus),
        .txdata(txdata), .tx_valid(tx_valid), .tx_req(tx_req),
        .rxdata(rxdata), .rx_valid(rx_valid), .rw(rw), .busy(busy),
        .start_det(start_det), .stop_det(stop_det), .tx_underrun(tx_underrun)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboards and event monitor ----------------
    logic [7:0] exp_rx[$];
    logic [7:0] exp_rd[$];
    int n_txreq = 0, n_rxv = 0, n_under = 0, n_start = 0, n_stop = 0;
    int n_busy_cyc = 0, n_busy_fall = 0, n_dut_sda = 0;
    logic busy_q = 1'b0;

    always @(negedge clk) begin
        if (tx_req)      n_txreq++;
        if (tx_underrun) n_under++;
        if (start_det)   n_start++;
        if (stop_det)    n_stop++;
        if (busy)        n_busy_cyc++;
        if (busy_q && !busy) n_busy_fall++;
        busy_q = busy;
        if (!m_sda_low && sda_bus === 1'b0) n_dut_sda++;
        if (rx_valid) begin
            n_rxv++;
            if (exp_rx.size() > 0) check("rxdata", 32'(rxdata), 32'(exp_rx.pop_front()));
            else                   check("rx_unexpected", 32'(rxdata), 32'h100);
        end
    end

    // ---------------- bit-banged master ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_scl_high();
        int n = 0;
        while (scl_bus !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (scl_bus !== 1'b1) check("scl_release", 32'(scl_bus), 32'd1);
    endtask

    task automatic send_bit(input logic b);
        tick(Q); m_sda_low = ~b;
        tick(Q); m_scl_low = 1'b0;
        wait_scl_high();
        tick(2 * Q); m_scl_low = 1'b1;
    endtask

    task automatic recv_bit(output logic b);
        tick(Q); m_sda_low = 1'b0;
        tick(Q); m_scl_low = 1'b0;
        wait_scl_high();
        tick(Q); b = sda_bus;
        tick(Q); m_scl_low = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
    endtask

    task automatic bus_start();
        m_sda_low = 1'b1;
        tick(2 * Q); m_scl_low = 1'b1;
    endtask

    task automatic bus_rstart();
        tick(Q); m_sda_low = 1'b0;
        tick(Q); m_scl_low = 1'b0;
        wait_scl_high();
        tick(Q); m_sda_low = 1'b1;
        tick(Q); m_scl_low = 1'b1;
    endtask

    task automatic bus_stop();
        tick(Q); m_sda_low = 1'b1;
        tick(Q); m_scl_low = 1'b0;
        wait_scl_high();
        tick(Q); m_sda_low = 1'b0;
        tick(2 * Q);
    endtask

    function automatic logic [31:0] outs();
        return 32'({tx_req, rxdata, rx_valid, rw, busy, start_det, stop_det, tx_underrun});
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        int s_rx, s_start, s_stop, s_txreq, s_under, s_busy, s_fall, s_sda;

        reset_n = 1'b0; tx_valid = 1'b0; txdata = 8'h00;
        m_scl_low = 1'b0; m_sda_low = 1'b0;
        tick(3);
        check("rst_outs", outs(), 32'd0);
        check("rst_sda",  32'(sda_bus), 32'd1);
        check("rst_scl",  32'(scl_bus), 32'd1);
        reset_n = 1'b1;
        tick(4);

        // 1: write 0xAA to 0x52
        s_rx = n_rxv; s_start = n_start; s_stop = n_stop;
        bus_start();
        send_byte(8'hA4, ack);
        check("t1_addr_ack", 32'(ack), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_rw", 32'(rw), 32'd0);
        exp_rx.push_back(8'hAA);
        send_byte(8'hAA, ack);
        check("t1_data_ack", 32'(ack), 32'd0);
        check("t1_busy_data", 32'(busy), 32'd1);
        bus_stop();
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_rx_cnt", 32'(n_rxv - s_rx), 32'd1);
        check("t1_start_cnt", 32'(n_start - s_start), 32'd1);
        check("t1_stop_cnt", 32'(n_stop - s_stop), 32'd1);

        // 2: address mismatch
        s_rx = n_rxv; s_start = n_start; s_stop = n_stop;
        s_busy = n_busy_cyc; s_sda = n_dut_sda;
        bus_start();
        send_byte(8'hA6, ack);
        check("t2_addr_nack", 32'(ack), 32'd1);
        send_byte(8'h55, ack);
        check("t2_data_nack", 32'(ack), 32'd1);
        bus_stop();
        check("t2_sda_driven", 32'(n_dut_sda - s_sda), 32'd0);
        check("t2_rx_cnt", 32'(n_rxv - s_rx), 32'd0);
        check("t2_busy_cyc", 32'(n_busy_cyc - s_busy), 32'd0);
        check("t2_start_cnt", 32'(n_start - s_start), 32'd1);
        check("t2_stop_cnt", 32'(n_stop - s_stop), 32'd1);

        // 3: single-byte read of 0xCA, master NACK
        txdata = 8'hCA; tx_valid = 1'b1; exp_rd.push_back(8'hCA);
        s_txreq = n_txreq;
        bus_start();
        send_byte(8'hA5, ack);
        check("t3_addr_ack", 32'(ack), 32'd0);
        check("t3_rw", 32'(rw), 32'd1);
        recv_byte(d);
        check("t3_rdata", 32'(d), 32'(exp_rd.pop_front()));
        send_bit(1'b1);
        bus_stop();
        check("t3_txreq_cnt", 32'(n_txreq - s_txreq), 32'd1);
        check("t3_busy_after", 32'(busy), 32'd0);

        // 4: two-byte read, tx_valid low for the second byte
        txdata = 8'h3C; tx_valid = 1'b1; exp_rd.push_back(8'h3C);
        s_txreq = n_txreq; s_under = n_under;
        bus_start();
        send_byte(8'hA5, ack);
        check("t4_addr_ack", 32'(ack), 32'd0);
        recv_byte(d);
        check("t4_rdata0", 32'(d), 32'(exp_rd.pop_front()));
        tx_valid = 1'b0;
        send_bit(1'b0);
`ifdef I2C_SLAVE_STRETCH_EN
        exp_rd.push_back(8'h5A);
        fork
            begin
                tick(30);
                check("t4_scl_held", 32'(scl_bus), 32'd0);
                txdata = 8'h5A; tx_valid = 1'b1;
            end
        join_none
`else
        exp_rd.push_back(8'hFF);
`endif
        recv_byte(d);
        check("t4_rdata1", 32'(d), 32'(exp_rd.pop_front()));
        send_bit(1'b1);
        bus_stop();
        check("t4_txreq_cnt", 32'(n_txreq - s_txreq), 32'd2);
`ifdef I2C_SLAVE_STRETCH_EN
        check("t4_underrun_cnt", 32'(n_under - s_under), 32'd0);
`else
        check("t4_underrun_cnt", 32'(n_under - s_under), 32'd1);
`endif

        // 5: write 0x11, repeated START, read 0x77
        txdata = 8'h77; tx_valid = 1'b1;
        s_start = n_start;
        bus_start();
        send_byte(8'hA4, ack);
        check("t5_addr_w_ack", 32'(ack), 32'd0);
        exp_rx.push_back(8'h11);
        send_byte(8'h11, ack);
        check("t5_data_ack", 32'(ack), 32'd0);
        check("t5_rw_w", 32'(rw), 32'd0);
        s_fall = n_busy_fall;
        bus_rstart();
        send_byte(8'hA5, ack);
        check("t5_addr_r_ack", 32'(ack), 32'd0);
        check("t5_rw_r", 32'(rw), 32'd1);
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_busy_fall", 32'(n_busy_fall - s_fall), 32'd0);
        exp_rd.push_back(8'h77);
        recv_byte(d);
        check("t5_rdata", 32'(d), 32'(exp_rd.pop_front()));
        send_bit(1'b1);
        bus_stop();
        check("t5_start_cnt", 32'(n_start - s_start), 32'd2);

        // 6: reset while the slave is pulling SDA low for the address ACK
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(1'(8'hA4 >> i));
        m_sda_low = 1'b0;
        tick(6);
        check("t6_ack_drive", 32'(sda_bus), 32'd0);
        reset_n = 1'b0;
        #1;
        check("t6_sda_release", 32'(sda_bus), 32'd1);
        check("t6_outs", outs(), 32'd0);
        m_scl_low = 1'b0;
        tick(4);
        reset_n = 1'b1;
        tick(4);
        s_rx = n_rxv;
        bus_start();
        send_byte(8'hA4, ack);
        check("t6_addr_ack", 32'(ack), 32'd0);
        exp_rx.push_back(8'h5C);
        send_byte(8'h5C, ack);
        check("t6_data_ack", 32'(ack), 32'd0);
        bus_stop();
        check("t6_rx_cnt", 32'(n_rxv - s_rx), 32'd1);

        check("rx_pending", 32'(exp_rx.size()), 32'd0);
        check("rd_pending", 32'(exp_rd.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
Single-address I2C target that sits on the same open-drain SCL/SDA bus as i2c_master and consumes its transactions. It oversamples the bus with the system clock, detects START/STOP, matches the 7-bit address, and acknowledges it. Written bytes go out on a byte-wide receive interface; read bytes come in on a byte-wide transmit interface. It serves as a synthesizable bus partner for master benches and as a register-bank front end in the design.

Parameters:
ADDRESS, 7'h52, 7-bit target address matched after START.
SYNC_STAGES, 2, flops in the SCL/SDA input synchronizers (min 2).

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
scl  inout  1  I2C clock; open-drain, released (z) unless stretching
sda  inout  1  I2C data; open-drain, driven only as 0 or z
txdata  input  8  byte to return on the next read data phase
tx_valid  input  1  txdata holds a valid byte
tx_req  output  1  one-clk pulse: the next read byte is needed
rxdata  output  8  last byte written by the master
rx_valid  output  1  one-clk pulse: rxdata updated
rw  output  1  R/W bit of the current addressed transaction
busy  output  1  high from address match to STOP/non-matching restart
start_det  output  1  one-clk pulse on START or repeated START
stop_det  output  1  one-clk pulse on STOP
tx_underrun  output  1  one-clk pulse: read byte loaded while tx_valid low

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, rxdata=0, sda and scl released (z), FSM=IDLE. Asserting reset mid-byte releases SDA immediately, with no wait for a clock edge.
- Inputs pass through SYNC_STAGES flops. Edge detect uses the previous synchronized sample. Bus timing requirement: SCL high and low each at least SYNC_STAGES+2 clk periods.
- START: synced SDA falls while SCL is high. STOP: synced SDA rises while SCL is high. Both are recognised in every state and take priority over bit events.
- Data sampling happens on the SCL rising edge, MSB first. SDA drive changes one clk after the SCL falling edge, which gives hold time.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- IDLE: START goes to ADDR and clears the bit counter.
- ADDR: shift 8 bits. On the 8th bit: if addr[7:1]==ADDRESS, latch rw, set busy, go to ADDR_ACK. Otherwise go to IGNORE and never drive SDA.
- ADDR_ACK: drive SDA=0 for the 9th clock (from the fall after bit 8 until the fall after the 9th rise).
  - If rw=1, tx_req pulses at the entry fall.
  - At the exit fall the shift register loads txdata if tx_valid=1. Otherwise it loads 8'hFF and tx_underrun pulses.
  - Next state is RD_DATA if rw=1, else WR_DATA.
- WR_DATA: shift 8 bits. At the fall after bit 8: rxdata updates, rx_valid pulses, go to WR_ACK.
- WR_ACK: drive SDA=0 for the 9th clock, then return to WR_DATA. Every written byte is ACKed.
- RD_DATA: drive SDA=0 for each 0 bit and release for each 1 bit; bits update on falls. At the fall after bit 8, release SDA and go to RD_ACK.
- RD_ACK: sample SDA on the 9th rise.
  - ACK (0): tx_req pulses immediately; at the next fall load txdata/FF as in ADDR_ACK; go to RD_DATA.
  - NACK (1): go to IGNORE and keep SDA released.
- IGNORE: SDA released; wait for START or STOP.
- STOP goes to IDLE, clears busy, and pulses stop_det.
- Repeated START from any state goes to ADDR and pulses start_det. busy stays high only if the new address matches.
- SDA must never be driven while SCL is high except during ACK or data-bit hold.

Optional Feature:
I2C_SLAVE_STRETCH_EN
- Defined: at the fall where a read byte would be loaded with tx_valid=0, hold SCL low (drive 0). When tx_valid rises, load txdata, present bit 7 on SDA, then release SCL after one clk. tx_underrun never pulses. A STOP or START seen during stretching releases SCL.
- Undefined: SCL is never driven (permanent z), and underrun loads 8'hFF as specified above.

Test Plan:
1. Write: START, 0xA4 (0x52,W), byte 0xAA, STOP -> ACK on both 9th clocks, one rx_valid pulse with rxdata=0xAA, busy high until stop_det.
2. Address mismatch: START, 0xA6 (0x53,W), 0x55, STOP -> SDA never driven, no rx_valid, busy stays 0, start_det and stop_det pulse.
3. Read: tx_valid=1, txdata=0xCA. START, 0xA5, master NACK, STOP -> SDA bits 1,1,0,0,1,0,1,0, exactly one tx_req pulse, FSM back to IDLE.
4. Two-byte read with master ACK then NACK, tx_valid=0 on the second byte -> second byte 0xFF, one tx_underrun pulse (macro undefined). Macro defined: SCL held low until tx_valid, no underrun pulse.
5. Repeated START: write 0x11, then Sr, 0xA5, read -> rw switches 0->1, busy stays high, start_det pulses twice.
6. reset_n low mid-byte while SDA is driven low -> SDA is z within the same time step, all outputs 0; after release the next valid write is accepted.
